// File: rtl/router_pkg.sv
// Shared router types and constants: packet field positions, output directions, route-stage FSM states.
// Imported by every input-port stage and the XY route helper.
package router_pkg;

   localparam int DATA_W  = 36;
   localparam int COORD_W = 3;

   localparam int DST_X_HI   = 35;
   localparam int DST_X_LO   = 33;
   localparam int DST_Y_HI   = 32;
   localparam int DST_Y_LO   = 30;
   localparam int PAYLOAD_HI = 29;
   localparam int PAYLOAD_LO = 0;

   // Enum value doubles as the bit index in the one-hot {L,W,S,E,N} request vector.
   typedef enum logic [2:0] {
      DIR_N = 3'd0,
      DIR_E = 3'd1,
      DIR_S = 3'd2,
      DIR_W = 3'd3,
      DIR_L = 3'd4
   } dir_e;

   localparam int IDX_N = 0;
   localparam int IDX_E = 1;
   localparam int IDX_S = 2;
   localparam int IDX_W = 3;
   localparam int IDX_L = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_REQ  = 2'd2
   } state_e;

   function automatic logic [4:0] dir_to_onehot(input dir_e d);
      logic [4:0] v;
      v = '0;
      case (d)
         DIR_N:   v[IDX_N] = 1'b1;
         DIR_E:   v[IDX_E] = 1'b1;
         DIR_S:   v[IDX_S] = 1'b1;
         DIR_W:   v[IDX_W] = 1'b1;
         default: v[IDX_L] = 1'b1;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/route_stage_if.sv
// Bundle between a route stage, its input FIFO and the crossbar output arbiter.
// master = route stage side; slave = FIFO/arbiter side.
interface route_stage_if #(
   parameter int DATA_W = router_pkg::DATA_W
);
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_q;
   logic              fifo_rd_req;
   logic [4:0]        out_req;
   logic [4:0]        out_gnt;
   logic              out_valid;
   logic [DATA_W-1:0] out_packet;
   logic [15:0]       pkt_count;

   modport master (
      input  fifo_empty, fifo_q, out_gnt,
      output fifo_rd_req, out_req, out_valid, out_packet, pkt_count
   );

   modport slave (
      output fifo_empty, fifo_q, out_gnt,
      input  fifo_rd_req, out_req, out_valid, out_packet, pkt_count
   );
endinterface

// File: rtl/xy_route.sv
// Dimension-ordered XY routing: resolve X first, then Y, else deliver locally.
// Purely combinational, no state, no backpressure.
module xy_route
   import router_pkg::*;
#(
   parameter int COORD_W = 3
) (
   input  logic [COORD_W-1:0] dst_x,
   input  logic [COORD_W-1:0] dst_y,
   input  logic [COORD_W-1:0] local_x,
   input  logic [COORD_W-1:0] local_y,
   output logic [4:0]         route_dir
);

   dir_e dir;

   always_comb begin
      dir = DIR_L;
      if (dst_x > local_x)      dir = DIR_E;
      else if (dst_x < local_x) dir = DIR_W;
      else if (dst_y > local_y) dir = DIR_N;
      else if (dst_y < local_y) dir = DIR_S;
      route_dir = dir_to_onehot(dir);
   end

endmodule

// File: rtl/route_stage.sv
// Input-port route stage: pops one flit, routes XY, requests the crossbar; pop->request 2 cycles, 1 pkt/2 cycles best case.
// Request and packet hold until granted; no FIFO pop while the grant is withheld.
module route_stage #(
   parameter int DATA_W  = router_pkg::DATA_W,
   parameter int COORD_W = router_pkg::COORD_W,
   parameter int LOCAL_X = 0,
   parameter int LOCAL_Y = 0
) (
   input logic         clk,
   input logic         rst_n,
   route_stage_if.master bus
);
   import router_pkg::*;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] hold_q;
   logic [4:0]        dir_q;
   logic [4:0]        route_dir;
   logic [4:0]        req;
   logic [15:0]       pkt_count_q;
   logic              grant;
   logic              pop;

   xy_route #(.COORD_W(COORD_W)) u_xy_route (
      .dst_x     (bus.fifo_q[DST_X_HI:DST_X_LO]),
      .dst_y     (bus.fifo_q[DST_Y_HI:DST_Y_LO]),
      .local_x   (COORD_W'(LOCAL_X)),
      .local_y   (COORD_W'(LOCAL_Y)),
      .route_dir (route_dir)
   );

   // dir_q keeps the last route after a transfer, so the request is masked outside REQ.
   assign req   = (state_q == ST_REQ) ? dir_q : 5'b0;
   assign grant = |(bus.out_gnt & req);

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!bus.fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: state_d = ST_REQ;
         ST_REQ: begin
            if (grant) begin
               if (!bus.fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         dir_q       <= '0;
         pkt_count_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_WAIT) begin
            hold_q <= bus.fifo_q;
            dir_q  <= route_dir;
         end
         if (grant) pkt_count_q <= pkt_count_q + 16'd1;
      end
   end

   // Gated by rst_n so nothing pops or transfers while reset is held.
   assign bus.fifo_rd_req = pop & rst_n;
   assign bus.out_valid   = grant & rst_n;
   assign bus.out_req     = req;
   assign bus.out_packet  = hold_q;
   assign bus.pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_route_stage.sv
// Directed bench for route_stage (LOCAL = (2,2)) with a transaction-level model checked every cycle.
module tb_route_stage;

   logic clk;
   logic rst_n;

   route_stage_if #(.DATA_W(36)) bus();

   route_stage #(.DATA_W(36), .COORD_W(3), .LOCAL_X(2), .LOCAL_Y(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [35:0] fq[$];

   // Model: a packet is either pending (popped, not yet presented) or held (presented and requesting).
   bit          m_init = 1'b0;
   bit          m_hold = 1'b0;
   bit          m_pend = 1'b0;
   logic [35:0] m_pkt      = '0;
   logic [35:0] m_pend_pkt = '0;
   logic [15:0] m_cnt      = '0;

   logic [4:0]  s_req;
   logic        s_valid;
   logic        s_rd;
   logic [35:0] s_pkt;
   logic [15:0] s_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [4:0] route(input logic [35:0] p);
      int x;
      int y;
      x = int'(p[35:33]);
      y = int'(p[32:30]);
      if (x > 2) return 5'b00010;
      if (x < 2) return 5'b01000;
      if (y > 2) return 5'b00001;
      if (y < 2) return 5'b00100;
      return 5'b10000;
   endfunction

   function automatic logic [35:0] mk(input logic [2:0] x, input logic [2:0] y, input logic [29:0] pay);
      return {x, y, pay};
   endfunction

   task automatic push(input logic [35:0] p);
      fq.push_back(p);
      bus.fifo_empty = 1'b0;
   endtask

   // One clock cycle: sample and compare at the falling edge, then play the FIFO after the rising edge.
   task automatic step();
      logic [4:0] e_req;
      logic       e_grant;
      logic       e_pop;
      @(negedge clk);
      s_req   = bus.out_req;
      s_valid = bus.out_valid;
      s_rd    = bus.fifo_rd_req;
      s_pkt   = bus.out_packet;
      s_cnt   = bus.pkt_count;
      e_req   = m_hold ? route(m_pkt) : 5'b0;
      e_grant = m_hold && ((bus.out_gnt & e_req) != 5'b0);
      e_pop   = rst_n && !bus.fifo_empty && ((!m_hold && !m_pend) || e_grant);
      if (m_init) begin
         chk("m_out_req",    64'(s_req),   64'(e_req));
         chk("m_out_valid",  64'(s_valid), 64'(rst_n && e_grant));
         chk("m_fifo_rd",    64'(s_rd),    64'(e_pop));
         chk("m_out_packet", 64'(s_pkt),   64'(m_pkt));
         chk("m_pkt_count",  64'(s_cnt),   64'(m_cnt));
      end
      if (!rst_n) begin
         m_hold = 1'b0;
         m_pend = 1'b0;
         m_pkt  = '0;
         m_cnt  = '0;
         m_init = 1'b1;
      end else if (m_init) begin
         if (e_grant) begin
            m_hold = 1'b0;
            m_cnt  = m_cnt + 16'd1;
         end
         if (m_pend) begin
            m_hold = 1'b1;
            m_pkt  = m_pend_pkt;
            m_pend = 1'b0;
         end
         if (e_pop && fq.size() > 0) begin
            m_pend     = 1'b1;
            m_pend_pkt = fq[0];
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (s_rd === 1'b1) begin
         if (fq.size() == 0) chk("underflow", 64'(1), 64'(0));
         else bus.fifo_q = fq.pop_front();
      end
      bus.fifo_empty = (fq.size() == 0);
   endtask

   logic [4:0] exp_routes[4];
   int         pops[$];
   int         vals[$];
   int         n;
   bit         stable;

   initial begin
      rst_n          = 1'b0;
      bus.out_gnt    = 5'b0;
      bus.fifo_q     = '0;
      bus.fifo_empty = 1'b1;
      push(36'hA_0000_0001);

      // Reset held 3 cycles with a packet waiting
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_rd_req", 64'(s_rd), 64'(0));
         chk("rst_valid",  64'(s_valid), 64'(0));
         if (i > 0) begin
            chk("rst_out_req", 64'(s_req), 64'(0));
            chk("rst_packet",  64'(s_pkt), 64'(0));
            chk("rst_count",   64'(s_cnt), 64'(0));
         end
      end

      // Single packet to E with immediate grant
      rst_n       = 1'b1;
      bus.out_gnt = 5'b00010;
      step();
      chk("first_pop", 64'(s_rd), 64'(1));
      step();
      chk("wait_req", 64'(s_req), 64'(0));
      step();
      chk("e_req",    64'(s_req),   64'(5'b00010));
      chk("e_valid",  64'(s_valid), 64'(1));
      chk("e_packet", 64'(s_pkt),   64'(36'hA00000001));
      chk("e_no_pop", 64'(s_rd),    64'(0));
      step();
      chk("count1",    64'(s_cnt), 64'(1));
      chk("idle_req0", 64'(s_req), 64'(0));

      // Route coverage: L, N, S, W
      exp_routes  = '{5'b10000, 5'b00001, 5'b00100, 5'b01000};
      bus.out_gnt = 5'b11111;
      push(mk(3'd2, 3'd2, 30'h11));
      push(mk(3'd2, 3'd5, 30'h22));
      push(mk(3'd2, 3'd0, 30'h33));
      push(mk(3'd0, 3'd2, 30'h44));
      n = 0;
      for (int i = 0; i < 20 && n < 4; i++) begin
         step();
         if (s_valid) begin
            chk($sformatf("route%0d", n), 64'(s_req), 64'(exp_routes[n]));
            n++;
         end
      end
      chk("route_done", 64'(n), 64'(4));
      step();

      // Grant withheld, then a wrong-bit grant, then the right one
      bus.out_gnt = 5'b0;
      push(mk(3'd5, 3'd1, 30'h55));
      push(mk(3'd0, 3'd2, 30'h66));
      for (int i = 0; i < 6; i++) begin
         step();
         if (s_req != 5'b0) break;
      end
      chk("stall_reach", 64'(s_req), 64'(5'b00010));
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (s_req !== 5'b00010 || s_valid !== 1'b0 || s_rd !== 1'b0) stable = 1'b0;
      end
      chk("stall_hold", 64'(stable), 64'(1));
      bus.out_gnt = 5'b00001;
      stable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (s_req !== 5'b00010 || s_valid !== 1'b0 || s_rd !== 1'b0) stable = 1'b0;
      end
      chk("wrong_gnt", 64'(stable), 64'(1));
      bus.out_gnt = 5'b00010;
      step();
      chk("stall_valid",  64'(s_valid), 64'(1));
      chk("stall_pop",    64'(s_rd),    64'(1));
      chk("stall_packet", 64'(s_pkt),   64'(mk(3'd5, 3'd1, 30'h55)));
      bus.out_gnt = 5'b01000;
      step();
      step();
      chk("w_req",    64'(s_req),   64'(5'b01000));
      chk("w_valid",  64'(s_valid), 64'(1));
      chk("w_no_pop", 64'(s_rd),    64'(0));
      bus.out_gnt = 5'b0;
      step();
      step();

      // Four queued packets, grant tied to the request
      push(mk(3'd3, 3'd2, 30'h1));
      push(mk(3'd1, 3'd2, 30'h2));
      push(mk(3'd2, 3'd4, 30'h3));
      push(mk(3'd2, 3'd1, 30'h4));
      for (int i = 0; i < 14; i++) begin
         bus.out_gnt = bus.out_req;
         step();
         if (s_rd) pops.push_back(i);
         if (s_valid) vals.push_back(i);
      end
      chk("tp_pops", 64'(pops.size()), 64'(4));
      chk("tp_vals", 64'(vals.size()), 64'(4));
      for (int k = 0; k < 4 && k < pops.size(); k++) chk($sformatf("tp_pop%0d", k), 64'(pops[k]), 64'(2 * k));
      for (int k = 0; k < 4 && k < vals.size(); k++) chk($sformatf("tp_val%0d", k), 64'(vals[k]), 64'(2 * k + 2));

      // Reset mid-operation discards the held packet
      bus.out_gnt = 5'b0;
      push(mk(3'd0, 3'd0, 30'h77));
      for (int i = 0; i < 3; i++) step();
      chk("mid_req", 64'(s_req), 64'(5'b01000));
      rst_n = 1'b0;
      step();
      rst_n       = 1'b1;
      bus.out_gnt = 5'b11111;
      stable      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (s_req !== 5'b0 || s_valid !== 1'b0 || s_pkt !== 36'h0 || s_cnt !== 16'h0) stable = 1'b0;
      end
      chk("mid_rst_clean", 64'(stable), 64'(1));

      // Counter wrap: preset near the top, then two transfers
      bus.out_gnt = 5'b0;
      force dut.pkt_count_q = 16'hFFFE;
      #1;
      release dut.pkt_count_q;
      m_cnt = 16'hFFFE;
      push(mk(3'd4, 3'd4, 30'h8));
      push(mk(3'd2, 3'd3, 30'h9));
      n = 0;
      for (int i = 0; i < 10; i++) begin
         bus.out_gnt = bus.out_req;
         step();
         if (s_valid) begin
            n++;
            if (n == 2) chk("pre_wrap", 64'(s_cnt), 64'(16'hFFFF));
         end
      end
      chk("wrap_n", 64'(n), 64'(2));
      chk("wrap",   64'(s_cnt), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
